// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the UART controller (master) and the TX serializer (slave).
// Carries the start strobe and data byte one way, and busy/done/serial line the other.
interface uart_tx_serializer_if;
   logic       i_start;
   logic [7:0] i_data;
   logic       o_busy;
   logic       o_done;
   logic       o_tx;

   modport master (output i_start, output i_data, input o_busy, input o_done, input o_tx);
   modport slave  (input i_start, input i_data, output o_busy, output o_done, output o_tx);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmit serializer with an internal baud divider.
// Accepts a byte on a start strobe while idle and reports busy/done per frame.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_serializer_if.slave  tx_if
);
   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;

   assign bit_end = (baud_cnt_q == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // The divider free-runs through every non-idle state and wraps at each bit boundary.
      if (state_q != S_IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_if.i_start) begin
               shift_d    = tx_if.i_data;
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  tx_d      = 1'b1;
                  state_d   = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         S_STOP: begin
            // bit_idx is reused to count stop bits so 8N2 needs no extra counter.
            if (bit_end) begin
               if (bit_idx_q == STOP_LAST) begin
                  bit_idx_d = '0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tx_if.o_tx   = tx_q;
   assign tx_if.o_busy = busy_q;
   assign tx_if.o_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame table, corner-case sequences and a queue-based line model.
// DUT1 runs 8N1 and DUT2 runs 8N2, both at 4 clocks per bit.
module tb_uart_tx_serializer;
   localparam int C = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   uart_tx_serializer_if if1 ();
   uart_tx_serializer_if if2 ();

   uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .tx_if (if1.slave)
   );

   uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .tx_if (if2.slave)
   );

   always #5 clk = ~clk;

   // Reference: an accepted byte expands into the whole per-cycle line waveform in a queue.
   logic m_tx   = 1'b1;
   logic m_busy = 1'b0;
   logic m_done = 1'b0;
   bit   line_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q.delete();
         m_tx   <= 1'b1;
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (line_q.size() != 0) begin
         m_tx   <= line_q.pop_front();
         m_busy <= 1'b1;
         m_done <= 1'b0;
      end else if (m_busy) begin
         m_tx   <= 1'b1;
         m_busy <= 1'b0;
         m_done <= 1'b1;
      end else begin
         m_tx   <= 1'b1;
         m_done <= 1'b0;
         if (if1.i_start === 1'b1) begin
            for (int k = 0; k < 10; k++) begin
               for (int r = 0; r < C; r++) begin
                  if (k == 0)      line_q.push_back(1'b0);
                  else if (k == 9) line_q.push_back(1'b1);
                  else             line_q.push_back(if1.i_data[k-1]);
               end
            end
            m_tx   <= line_q.pop_front();
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         tests++;
         if ({if1.o_tx, if1.o_busy, if1.o_done} !== {m_tx, m_busy, m_done}) begin
            fails++;
            $display("[TB] FAIL model_cycle t=%0t tx/busy/done got %b%b%b expected %b%b%b",
                     $time, if1.o_tx, if1.o_busy, if1.o_done, m_tx, m_busy, m_done);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_wave(input logic [10:0] fr, input int nbits);
      logic [63:0] w;
      w = '1;
      for (int c = 0; c < nbits * C; c++) w[c] = fr[c / C];
      return w;
   endfunction

   // Sends one byte on DUT1; returns at the o_done cycle with the sampled line and latency.
   task automatic run_frame(input logic [7:0] d, input int intrude_at, input logic [7:0] intr,
                            output logic [63:0] wave, output int lat);
      wave = '1;
      lat  = -1;
      if1.i_start = 1'b1;
      if1.i_data  = d;
      tick();
      if1.i_start = 1'b0;
      if1.i_data  = ~d;
      for (int c = 0; c < 60; c++) begin
         if (if1.o_done === 1'b1) begin
            lat = c + 1;
            break;
         end
         wave[c] = if1.o_tx;
         if (c == intrude_at) begin
            if1.i_start = 1'b1;
            if1.i_data  = intr;
         end
         tick();
         if1.i_start = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         intrude_at;
      logic [7:0] intr;
      logic [9:0] frame;   // transmit order: bit 0 is the start bit
      int         lat;
   } vec_t;

   vec_t        tbl[6];
   logic [63:0] wave;
   int          lat;
   int          bad;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'hA5, -1, 8'h00, 10'b1_1010_0101_0, 41};
      tbl[1] = '{8'hA5,  9, 8'h3C, 10'b1_1010_0101_0, 41};
      tbl[2] = '{8'h00, -1, 8'h00, 10'b1_0000_0000_0, 41};
      tbl[3] = '{8'hFF, -1, 8'h00, 10'b1_1111_1111_0, 41};
      tbl[4] = '{8'h81, 20, 8'hFF, 10'b1_1000_0001_0, 41};
      tbl[5] = '{8'h6E, -1, 8'h00, 10'b1_0110_1110_0, 41};

      if1.i_start = 1'b0; if1.i_data = 8'h00;
      if2.i_start = 1'b0; if2.i_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;

      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if ({if1.o_tx, if1.o_busy, if1.o_done} !== 3'b100) bad++;
         if ({if2.o_tx, if2.o_busy, if2.o_done} !== 3'b100) bad++;
      end
      check("idle_after_reset", 64'(bad), 64'd0);
      tick();

      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i].data, tbl[i].intrude_at, tbl[i].intr, wave, lat);
         $display("[TB] frame %0d data=%02h intrude_at=%0d done_latency=%0d", i, tbl[i].data, tbl[i].intrude_at, lat);
         check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
         check($sformatf("tbl%0d_wave", i), wave, exp_wave({1'b1, tbl[i].frame}, 10));
         bad = 0;
         repeat (45) begin
            tick();
            if ({if1.o_tx, if1.o_busy, if1.o_done} !== 3'b100) bad++;
         end
         check($sformatf("tbl%0d_quiet_after", i), 64'(bad), 64'd0);
      end

      // Back-to-back: the second start is raised in the o_done cycle of the first.
      run_frame(8'hA5, -1, 8'h00, wave, lat);
      check("b2b_first_latency", 64'(lat), 64'd41);
      run_frame(8'h00, -1, 8'h00, wave, lat);
      $display("[TB] back-to-back second frame done_latency=%0d", lat);
      check("b2b_second_latency", 64'(lat), 64'd41);
      check("b2b_second_wave", wave, exp_wave(11'b11_0000_0000_0, 10));
      repeat (3) tick();

      // Reset in the middle of data bit 3.
      if1.i_start = 1'b1;
      if1.i_data  = 8'h52;
      tick();
      if1.i_start = 1'b0;
      repeat (17) tick();
      check("pre_reset_tx", 64'(if1.o_tx), 64'd0);
      #2 reset = 1'b1;
      #1;
      $display("[TB] mid-frame reset tx/busy/done=%b%b%b", if1.o_tx, if1.o_busy, if1.o_done);
      check("reset_immediate", 64'({if1.o_tx, if1.o_busy, if1.o_done}), 64'(3'b100));
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if ({if1.o_tx, if1.o_done} !== 2'b10) bad++;
      end
      check("reset_hold_no_done", 64'(bad), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      run_frame(8'hFF, -1, 8'h00, wave, lat);
      check("post_reset_latency", 64'(lat), 64'd41);
      check("post_reset_wave", wave, exp_wave(11'b11_1111_1111_0, 10));
      tick();

      // Random strobes and data; the model monitor checks every cycle.
      repeat (600) begin
         if1.i_start = ($urandom_range(0, 7) == 0);
         if1.i_data  = 8'($urandom);
         tick();
      end
      if1.i_start = 1'b1;
      repeat (100) begin
         if1.i_data = 8'($urandom);
         tick();
      end
      if1.i_start = 1'b0;
      repeat (50) tick();
      check("random_end_idle", 64'({if1.o_tx, if1.o_busy, if1.o_done}), 64'(3'b100));

      // Two stop bits on DUT2.
      wave = '1;
      lat  = -1;
      if2.i_start = 1'b1;
      if2.i_data  = 8'h81;
      tick();
      if2.i_start = 1'b0;
      if2.i_data  = 8'h00;
      for (int c = 0; c < 64; c++) begin
         if (if2.o_done === 1'b1) begin
            lat = c + 1;
            break;
         end
         wave[c] = if2.o_tx;
         tick();
      end
      $display("[TB] 8N2 frame data=81 done_latency=%0d", lat);
      check("stop2_latency", 64'(lat), 64'd45);
      check("stop2_wave", wave, exp_wave(11'b11_1000_0001_0, 11));
      check("stop2_done_busy", 64'({if2.o_busy, if2.o_done}), 64'(2'b01));
      tick();
      check("stop2_idle", 64'({if2.o_tx, if2.o_busy, if2.o_done}), 64'(3'b100));

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
